// File: rtl/xxd_pkg.sv
// xxd_pkg: shared state encoding, ASCII constants and printable-byte mapping for the xxd line scheduler
package xxd_pkg;
    typedef enum logic [3:0] {
        FILL,
        EMIT_OFF,
        EMIT_COLON,
        EMIT_SP,
        EMIT_HEX_HI,
        EMIT_HEX_LO,
        EMIT_GSP,
        EMIT_SEP,
        EMIT_ASC,
        EMIT_NL
    } state_t;
    localparam logic [7:0] SPACE = 8'h20;
    localparam logic [7:0] COLON = 8'h3A;
    localparam logic [7:0] DOT = 8'h2E;
    localparam logic [7:0] NL = 8'h0A;
    localparam logic [7:0] PRINT_LO = 8'h20;
    localparam logic [7:0] PRINT_HI = 8'h7E;
    function automatic logic [7:0] printable(input logic [7:0] b);
        return (b < PRINT_LO || b > PRINT_HI) ? DOT : b;
    endfunction
endpackage

// File: rtl/xxd_line_scheduler_if.sv
// xxd_line_scheduler_if: byte-in / character-out handshake bundle of the line scheduler
interface xxd_line_scheduler_if;
    logic [7:0] in_data;
    logic in_valid;
    logic in_last;
    logic in_ready;
    logic [7:0] out_char;
    logic out_valid;
    logic out_ready;
    logic busy;
    modport master (
        output in_data, in_valid, in_last, out_ready,
        input in_ready, out_char, out_valid, busy
    );
    modport slave (
        input in_data, in_valid, in_last, out_ready,
        output in_ready, out_char, out_valid, busy
    );
endinterface

// File: rtl/xxd_nibble_to_ascii.sv
// xxd_nibble_to_ascii: 4-bit value to lowercase ASCII hex digit
module xxd_nibble_to_ascii (
    input logic [3:0] nib,
    output logic [7:0] ch
);
    assign ch = nib < 4'd10 ? 8'h30 + {4'd0, nib} : 8'h57 + {4'd0, nib};
endmodule

// File: rtl/xxd_line_scheduler.sv
// xxd_line_scheduler: buffers one line of bytes and streams it out as an xxd-format text line
module xxd_line_scheduler
    import xxd_pkg::*;
#(
    parameter int BYTES_PER_LINE = 16,
    parameter int GROUP_BYTES = 2,
    parameter int OFFSET_DIGITS = 8
) (
    input logic clk,
    input logic rst,
    input logic ena,
    xxd_line_scheduler_if.slave bus
);
    localparam int LW = $clog2(BYTES_PER_LINE);
    localparam int CW = LW + 1;
    localparam int DW = $clog2(OFFSET_DIGITS) + 1;
    localparam int OW = 4 * OFFSET_DIGITS;
    localparam logic [CW-1:0] BPL = CW'(BYTES_PER_LINE);
    localparam logic [DW-1:0] LAST_DIGIT = DW'(OFFSET_DIGITS - 1);

    state_t state, state_n;
    logic [CW-1:0] count;
    logic [CW-1:0] idx;
    logic [DW-1:0] digit;
    logic [OW-1:0] offset;
    logic [OW-1:0] osh;
    logic [7:0] line_buf [BYTES_PER_LINE];
    logic [7:0] cur;
    logic [7:0] hex_ch;
    logic [3:0] nib;
    logic accept;
    logic adv;
    logic slot_used;
    logic group_end;

    assign cur = line_buf[idx[LW-1:0]];
    assign bus.in_ready = ena && !rst && state == FILL;
    assign accept = bus.in_valid && bus.in_ready;
    assign bus.out_valid = state != FILL;
    assign bus.busy = state != FILL;
    assign adv = ena && bus.out_valid && bus.out_ready;
    assign slot_used = idx < count;
    assign group_end = ((int'(idx) + 1) % GROUP_BYTES) == 0;
    assign nib = state == EMIT_OFF ? osh[OW-1 -: 4] : state == EMIT_HEX_HI ? cur[7:4] : cur[3:0];

    xxd_nibble_to_ascii u_hex (
        .nib(nib),
        .ch(hex_ch)
    );

    // State register; rst wins over ena
    always_ff @(posedge clk) begin
        if (rst) state <= FILL;
        else if (ena) state <= state_n;
    end

    // Next state and the character presented in each emission state
    always_comb begin
        state_n = state;
        bus.out_char = 8'h00;
        case (state)
            FILL: if (accept && (count == BPL - 1'b1 || bus.in_last)) state_n = EMIT_OFF;
            EMIT_OFF: begin
                bus.out_char = hex_ch;
                if (adv && digit == LAST_DIGIT) state_n = EMIT_COLON;
            end
            EMIT_COLON: begin
                bus.out_char = COLON;
                if (adv) state_n = EMIT_SP;
            end
            EMIT_SP: begin
                bus.out_char = SPACE;
                if (adv) state_n = EMIT_HEX_HI;
            end
            EMIT_HEX_HI: begin
                bus.out_char = slot_used ? hex_ch : SPACE;
                if (adv) state_n = EMIT_HEX_LO;
            end
            EMIT_HEX_LO: begin
                bus.out_char = slot_used ? hex_ch : SPACE;
                if (adv) state_n = group_end ? EMIT_GSP : EMIT_HEX_HI;
            end
            EMIT_GSP: begin
                bus.out_char = SPACE;
                if (adv) state_n = idx == BPL - 1'b1 ? EMIT_SEP : EMIT_HEX_HI;
            end
            EMIT_SEP: begin
                bus.out_char = SPACE;
                if (adv) state_n = EMIT_ASC;
            end
            EMIT_ASC: begin
                bus.out_char = printable(cur);
                if (adv && idx == count - 1'b1) state_n = EMIT_NL;
            end
            EMIT_NL: begin
                bus.out_char = NL;
                if (adv) state_n = FILL;
            end
            default: state_n = FILL;
        endcase
    end

    // Counters: fill count, offset digit shifter, slot/ASCII index, running offset
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            idx <= '0;
            digit <= '0;
            offset <= '0;
            osh <= '0;
        end else if (ena) begin
            if (state == FILL) osh <= offset;
            if (accept) count <= count + 1'b1;
            if (adv) begin
                case (state)
                    EMIT_OFF: begin
                        digit <= digit == LAST_DIGIT ? '0 : digit + 1'b1;
                        osh <= osh << 4;
                    end
                    EMIT_HEX_LO: idx <= group_end ? idx : idx + 1'b1;
                    EMIT_GSP: idx <= idx == BPL - 1'b1 ? '0 : idx + 1'b1;
                    EMIT_ASC: idx <= idx + 1'b1;
                    EMIT_NL: begin
                        offset <= offset + OW'(count);
                        count <= '0;
                        idx <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Line buffer write on each accepted byte; stale contents are never read past count
    always_ff @(posedge clk) begin
        if (accept) line_buf[count[LW-1:0]] <= bus.in_data;
    end
endmodule

// File: tb/tb_xxd_line_scheduler.sv
// tb_xxd_line_scheduler: randomized self-checking bench against a string-building model of xxd lines
module tb_xxd_line_scheduler;
    typedef logic [7:0] bq_t[$];

    logic clk = 0;
    logic rst = 1;
    logic ena = 1;
    int total = 0;
    int bad = 0;
    bq_t got1, got2;
    longint off1 = 0;
    longint off2 = 0;

    always #5 clk = ~clk;

    xxd_line_scheduler_if i1 ();
    xxd_line_scheduler_if i2 ();

    xxd_line_scheduler #(.BYTES_PER_LINE(16), .GROUP_BYTES(2), .OFFSET_DIGITS(8)) dut (
        .clk(clk), .rst(rst), .ena(ena), .bus(i1)
    );
    xxd_line_scheduler #(.BYTES_PER_LINE(16), .GROUP_BYTES(2), .OFFSET_DIGITS(2)) dut2 (
        .clk(clk), .rst(rst), .ena(ena), .bus(i2)
    );

    // Record every character that will transfer on the coming rising edge
    always @(negedge clk) begin
        if (!rst && ena && i1.out_valid && i1.out_ready) got1.push_back(i1.out_char);
        if (!rst && ena && i2.out_valid && i2.out_ready) got2.push_back(i2.out_char);
    end

    function automatic logic [7:0] hexc(input int v);
        return v < 10 ? 8'(48 + v) : 8'(87 + v);
    endfunction

    // Expected text of one line at 16 bytes/line, 2-byte groups
    function automatic bq_t make_line(input longint off, input int od, input bq_t d);
        bq_t q;
        for (int k = od - 1; k >= 0; k--) q.push_back(hexc(int'((off >> (4 * k)) & 15)));
        q.push_back(8'h3A);
        q.push_back(8'h20);
        for (int i = 0; i < 16; i++) begin
            if (i < d.size()) begin
                q.push_back(hexc(int'(d[i]) / 16));
                q.push_back(hexc(int'(d[i]) % 16));
            end else begin
                q.push_back(8'h20);
                q.push_back(8'h20);
            end
            if ((i + 1) % 2 == 0) q.push_back(8'h20);
        end
        q.push_back(8'h20);
        foreach (d[i]) q.push_back((d[i] < 8'h20 || d[i] > 8'h7E) ? 8'h2E : d[i]);
        q.push_back(8'h0A);
        return q;
    endfunction

    function automatic int first_diff(input bq_t a, input bq_t b);
        int n = a.size() < b.size() ? a.size() : b.size();
        for (int i = 0; i < n; i++) if (a[i] !== b[i]) return i;
        return a.size() == b.size() ? -1 : n;
    endfunction

    function automatic int str_diff(input bq_t q, input int base, input string s);
        for (int i = 0; i < s.len(); i++) if (base + i >= q.size() || q[base + i] !== s[i]) return i;
        return -1;
    endfunction

    function automatic bq_t rand_bytes(input int n);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
        return q;
    endfunction

    task automatic send(input bit sel, input logic [7:0] b, input bit last);
        int n = 0;
        if (sel) begin
            i2.in_data = b; i2.in_valid = 1; i2.in_last = last;
        end else begin
            i1.in_data = b; i1.in_valid = 1; i1.in_last = last;
        end
        @(negedge clk);
        while (!(sel ? i2.in_ready : i1.in_ready) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            total++; bad++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
        end
        @(posedge clk); #1;
        i1.in_valid = 0; i1.in_last = 0; i2.in_valid = 0; i2.in_last = 0;
    endtask

    task automatic send_line(input bit sel, input bq_t d, input bit last);
        foreach (d[i]) send(sel, d[i], last && i == d.size() - 1);
    endtask

    task automatic wait_chars(input bit sel, input int n);
        int k = 0;
        while ((sel ? got2.size() : got1.size()) < n && k < 5000) begin
            @(posedge clk); #1;
            k++;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        got1.delete(); got2.delete();
        off1 = 0; off2 = 0;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (i1.out_valid !== 1'b0) begin bad++; $display("FAIL reset out_valid: got %b required 0", i1.out_valid); end
        total++; if (i1.in_ready !== 1'b0) begin bad++; $display("FAIL reset in_ready: got %b required 0", i1.in_ready); end
        total++; if (i1.busy !== 1'b0) begin bad++; $display("FAIL reset busy: got %b required 0", i1.busy); end
        total++; if (i1.out_char !== 8'h00) begin bad++; $display("FAIL reset out_char: got %h required 00", i1.out_char); end
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        total++; if (i1.in_ready !== 1'b1) begin bad++; $display("FAIL reset release in_ready: got %b required 1", i1.in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_full_line();
        bq_t d, exp;
        int e;
        for (int i = 0; i < 16; i++) d.push_back(8'(8'h41 + i));
        exp = make_line(off1, 8, d);
        got1.delete();
        send_line(0, d, 0);
        @(negedge clk);
        total++; if (i1.out_valid !== 1'b1) begin bad++; $display("FAIL full latency out_valid: got %b required 1", i1.out_valid); end
        total++; if (i1.busy !== 1'b1 || i1.in_ready !== 1'b0) begin bad++; $display("FAIL full busy/in_ready: got %b/%b required 1/0", i1.busy, i1.in_ready); end
        @(posedge clk); #1;
        wait_chars(0, 68);
        total++; if (got1.size() != 68) begin bad++; $display("FAIL full length: got %0d required 68", got1.size()); end
        e = first_diff(got1, exp);
        total++; if (e != -1) begin bad++; $display("FAIL full model: first diff at %0d (got len %0d, required len %0d)", e, got1.size(), exp.size()); end
        e = str_diff(got1, 0, "00000000: 4142 4344 4546 4748 494a 4b4c 4d4e 4f50  ABCDEFGHIJKLMNOP\n");
        total++; if (e != -1) begin bad++; $display("FAIL full literal: first diff at %0d", e); end
        off1 += 16;
    endtask

    task automatic test_partial();
        bq_t d, exp;
        int e;
        do_reset();
        d = '{8'h48, 8'h69, 8'h0A};
        exp = make_line(off1, 8, d);
        send_line(0, d, 1);
        wait_chars(0, 55);
        e = first_diff(got1, exp);
        total++; if (e != -1 || got1.size() != 55) begin bad++; $display("FAIL partial line: diff at %0d, got len %0d required 55", e, got1.size()); end
        off1 += 3;
        got1.delete();
        d = '{8'h7F};
        exp = make_line(off1, 8, d);
        send_line(0, d, 1);
        wait_chars(0, 53);
        e = str_diff(got1, 0, "00000003: 7f");
        total++; if (e != -1) begin bad++; $display("FAIL partial next offset: diff at %0d required 00000003: 7f", e); end
        e = first_diff(got1, exp);
        total++; if (e != -1) begin bad++; $display("FAIL partial next line: diff at %0d (got len %0d, required len %0d)", e, got1.size(), exp.size()); end
        off1 += 1;
    endtask

    task automatic test_second_line();
        bq_t d, exp, l2;
        int e;
        do_reset();
        for (int i = 0; i < 16; i++) d.push_back(8'h00);
        exp = make_line(0, 8, d);
        l2 = make_line(16, 8, d);
        foreach (l2[i]) exp.push_back(l2[i]);
        for (int i = 0; i < 32; i++) send(0, 8'h00, 0);
        wait_chars(0, 136);
        total++; if (got1.size() != 136) begin bad++; $display("FAIL second length: got %0d required 136", got1.size()); end
        e = str_diff(got1, 68, "00000010: 0000");
        total++; if (e != -1) begin bad++; $display("FAIL second prefix: diff at %0d", e); end
        e = str_diff(got1, 68 + 51, "................\n");
        total++; if (e != -1) begin bad++; $display("FAIL second ascii column: diff at %0d", e); end
        e = first_diff(got1, exp);
        total++; if (e != -1) begin bad++; $display("FAIL second model: diff at %0d", e); end
        off1 = 32;
    endtask

    task automatic test_backpressure();
        bq_t d, exp;
        int e, n, k;
        logic [7:0] held_c;
        bit held_v;
        for (int line = 0; line < 4; line++) begin
            n = line == 0 ? 16 : $urandom_range(1, 16);
            d = rand_bytes(n);
            exp = make_line(off1, 8, d);
            got1.delete();
            i1.out_ready = 1;
            send_line(0, d, n < 16 ? 1'b1 : 1'($urandom_range(0, 1)));
            held_v = 0;
            k = 0;
            i1.out_ready = 1'($urandom_range(0, 1));
            while (got1.size() < exp.size() && k < 3000) begin
                @(negedge clk);
                if (held_v) begin
                    total++;
                    if (i1.out_valid !== 1'b1 || i1.out_char !== held_c) begin
                        bad++; $display("FAIL bp stable: got %b/%h required 1/%h", i1.out_valid, i1.out_char, held_c);
                    end
                end
                if (i1.out_valid) begin
                    total++;
                    if (i1.in_ready !== 1'b0) begin bad++; $display("FAIL bp in_ready: got %b required 0", i1.in_ready); end
                end
                held_v = i1.out_valid && !i1.out_ready;
                held_c = i1.out_char;
                @(posedge clk); #1;
                i1.out_ready = 1'($urandom_range(0, 1));
                k++;
            end
            i1.out_ready = 1;
            wait_chars(0, exp.size());
            e = first_diff(got1, exp);
            total++; if (e != -1) begin bad++; $display("FAIL bp line %0d: diff at %0d (got len %0d, required len %0d)", line, e, got1.size(), exp.size()); end
            off1 = (off1 + n) % 64'h1_0000_0000;
        end
    endtask

    task automatic test_wrap();
        bq_t d, exp;
        int e;
        do_reset();
        for (int line = 0; line < 17; line++) begin
            d = rand_bytes(16);
            exp = make_line(off2, 2, d);
            got2.delete();
            send_line(1, d, 0);
            wait_chars(1, 62);
            e = first_diff(got2, exp);
            total++; if (e != -1) begin bad++; $display("FAIL wrap line %0d: diff at %0d (got len %0d, required len %0d)", line, e, got2.size(), exp.size()); end
            off2 = (off2 + 16) % 256;
        end
        e = str_diff(got2, 0, "00: ");
        total++; if (e != -1) begin bad++; $display("FAIL wrap 17th prefix: diff at %0d required 00: ", e); end
    endtask

    task automatic test_reset_mid();
        bq_t d, exp;
        int e;
        do_reset();
        send_line(0, rand_bytes(16), 0);
        wait_chars(0, 12);
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        total++; if (i1.out_valid !== 1'b0) begin bad++; $display("FAIL rst mid out_valid: got %b required 0", i1.out_valid); end
        total++; if (i1.in_ready !== 1'b0) begin bad++; $display("FAIL rst mid in_ready: got %b required 0", i1.in_ready); end
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        total++; if (i1.in_ready !== 1'b1) begin bad++; $display("FAIL rst mid release in_ready: got %b required 1", i1.in_ready); end
        @(posedge clk); #1;
        got1.delete();
        d = rand_bytes(5);
        exp = make_line(0, 8, d);
        send_line(0, d, 1);
        wait_chars(0, 57);
        e = str_diff(got1, 0, "00000000: ");
        total++; if (e != -1) begin bad++; $display("FAIL rst mid offset: diff at %0d required 00000000", e); end
        e = first_diff(got1, exp);
        total++; if (e != -1) begin bad++; $display("FAIL rst mid line: diff at %0d", e); end
        off1 = 5;
    endtask

    task automatic test_enable();
        bq_t d, exp;
        int e;
        logic [7:0] c;
        d = rand_bytes(16);
        exp = make_line(off1, 8, d);
        got1.delete();
        send_line(0, d, 0);
        wait_chars(0, 20);
        ena = 0;
        @(negedge clk);
        c = i1.out_char;
        repeat (5) begin
            @(posedge clk); #1;
            @(negedge clk);
            total++;
            if (i1.out_valid !== 1'b1 || i1.out_char !== c || i1.in_ready !== 1'b0) begin
                bad++; $display("FAIL ena hold: got %b/%h/%b required 1/%h/0", i1.out_valid, i1.out_char, i1.in_ready, c);
            end
        end
        @(posedge clk); #1;
        ena = 1;
        wait_chars(0, exp.size());
        total++; if (got1.size() <= 20 || got1[20] !== c) begin bad++; $display("FAIL ena resume char: got %h required %h", got1.size() > 20 ? got1[20] : 8'hxx, c); end
        e = first_diff(got1, exp);
        total++; if (e != -1) begin bad++; $display("FAIL ena line: diff at %0d (got len %0d, required len %0d)", e, got1.size(), exp.size()); end
        off1 += 16;
        ena = 0;
        @(negedge clk);
        total++; if (i1.in_ready !== 1'b0) begin bad++; $display("FAIL ena fill in_ready: got %b required 0", i1.in_ready); end
        @(posedge clk); #1;
        ena = 1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        i1.in_data = 0; i1.in_valid = 0; i1.in_last = 0; i1.out_ready = 1;
        i2.in_data = 0; i2.in_valid = 0; i2.in_last = 0; i2.out_ready = 1;
        test_reset();
        test_full_line();
        test_partial();
        test_second_line();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        test_enable();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
